demux_8_1_gate: RTL and testbench

1-to-8 demultiplexer built from primitive gates. Routes single-bit data input D to one of eight outputs Y0..Y7, selected by the 3-bit select S. Combinational outputs feed downstream glue logic directly. A clocked side path provides a registered copy of the outputs and sticky per-channel activity flags for debug and status reporting.

---
 rtl/demux_8_1_gate.sv | 51 +++++
 tb/tb_demux_8_1_gate.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/demux_8_1_gate.sv
// 1-to-8 gate-level demultiplexer with a registered copy of the outputs
// and sticky per-channel activity flags for status readback.
module demux_8_1_gate (
  input  logic       clk,
  input  logic       rst,
  input  logic       D,
  input  logic [2:0] S,
  output logic       Y0,
  output logic       Y1,
  output logic       Y2,
  output logic       Y3,
  output logic       Y4,
  output logic       Y5,
  output logic       Y6,
  output logic       Y7,
  output logic [7:0] y_q,
  output logic [7:0] hit
);

  logic s2_n;
  logic s1_n;
  logic s0_n;
  logic [7:0] y_vec;

  assign s2_n = ~S[2];
  assign s1_n = ~S[1];
  assign s0_n = ~S[0];

  // Each output is D gated by its select minterm; no clock or reset involvement.
  assign Y0 = D & s2_n & s1_n & s0_n;
  assign Y1 = D & s2_n & s1_n & S[0];
  assign Y2 = D & s2_n & S[1] & s0_n;
  assign Y3 = D & s2_n & S[1] & S[0];
  assign Y4 = D & S[2] & s1_n & s0_n;
  assign Y5 = D & S[2] & s1_n & S[0];
  assign Y6 = D & S[2] & S[1] & s0_n;
  assign Y7 = D & S[2] & S[1] & S[0];

  assign y_vec = {Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0};

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= 8'h00;
      hit <= 8'h00;
    end else begin
      y_q <= y_vec;
      hit <= hit | y_vec;
    end
  end

endmodule

// File: tb/tb_demux_8_1_gate.sv
// Self-checking bench for demux_8_1_gate: table-driven combinational vectors
// plus a scoreboard for the registered y_q/hit path.
module tb_demux_8_1_gate;

  logic       clk;
  logic       rst;
  logic       D;
  logic [2:0] S;
  logic       Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7;
  logic [7:0] y_q;
  logic [7:0] hit;
  logic [7:0] y_comb;

  demux_8_1_gate dut (
    .clk(clk), .rst(rst), .D(D), .S(S),
    .Y0(Y0), .Y1(Y1), .Y2(Y2), .Y3(Y3),
    .Y4(Y4), .Y5(Y5), .Y6(Y6), .Y7(Y7),
    .y_q(y_q), .hit(hit)
  );

  assign y_comb = {Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       d;
    logic [2:0] s;
    logic [7:0] y;
  } vec_t;

  typedef struct {
    logic [7:0] y_q;
    logic [7:0] hit;
  } exp_t;

  vec_t vecs[24];
  exp_t sb[$];
  logic [7:0] hit_m;
  int n_vec;
  int n_miscmp;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic r, input logic [7:0] y);
    exp_t e;
    if (r) hit_m = 8'h00;
    else   hit_m = hit_m | y;
    e.y_q = r ? 8'h00 : y;
    e.hit = hit_m;
    sb.push_back(e);
  endtask

  task automatic check_reg(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_miscmp++;
      $display("FAIL %s: scoreboard empty, got y_q %h expected an entry", name, y_q);
    end else begin
      e = sb.pop_front();
      chk({name, " y_q"}, y_q, e.y_q);
      chk({name, " hit"}, hit, e.hit);
    end
  endtask

  task automatic apply(input logic r, input logic d, input logic [2:0] s,
                       input logic [7:0] exp_y, input string name);
    @(negedge clk);
    rst = r; D = d; S = s;
    #1 chk({name, " comb"}, y_comb, exp_y);
    push_exp(r, exp_y);
    @(posedge clk);
    #1 check_reg(name);
  endtask

  initial begin
    logic rd;
    n_vec = 0;
    n_miscmp = 0;
    hit_m = 8'h00;
    rst = 1'b1; D = 1'b0; S = 3'b000;

    // D=1 sweep: one-hot at position S
    vecs[0]  = '{1'b0, 1'b1, 3'd0, 8'h01};
    vecs[1]  = '{1'b0, 1'b1, 3'd1, 8'h02};
    vecs[2]  = '{1'b0, 1'b1, 3'd2, 8'h04};
    vecs[3]  = '{1'b0, 1'b1, 3'd3, 8'h08};
    vecs[4]  = '{1'b0, 1'b1, 3'd4, 8'h10};
    vecs[5]  = '{1'b0, 1'b1, 3'd5, 8'h20};
    vecs[6]  = '{1'b0, 1'b1, 3'd6, 8'h40};
    vecs[7]  = '{1'b0, 1'b1, 3'd7, 8'h80};
    // D=0 sweep: all outputs low
    for (int i = 0; i < 8; i++) vecs[8 + i] = '{1'b0, 1'b0, 3'(i), 8'h00};
    // random D while S walks
    for (int i = 0; i < 8; i++) begin
      rd = 1'($urandom_range(0, 1));
      vecs[16 + i] = '{1'b0, rd, 3'(i), rd ? (8'h01 << i) : 8'h00};
    end

    apply(1'b1, 1'b0, 3'd0, 8'h00, "reset0");
    apply(1'b1, 1'b0, 3'd0, 8'h00, "reset1");

    for (int i = 0; i < 24; i++)
      apply(vecs[i].r, vecs[i].d, vecs[i].s, vecs[i].y, $sformatf("vec%0d", i));

    // hit accumulation after a fresh reset
    apply(1'b1, 1'b0, 3'd0, 8'h00, "rst_a");
    apply(1'b1, 1'b0, 3'd0, 8'h00, "rst_b");
    apply(1'b0, 1'b1, 3'd2, 8'h04, "seq_s2");
    chk("seq_s2 hit const", hit, 8'h04);
    apply(1'b0, 1'b1, 3'd7, 8'h80, "seq_s7");
    chk("seq_s7 hit const", hit, 8'h84);
    // reset wins over an active channel; Y0 stays combinationally high
    apply(1'b1, 1'b1, 3'd0, 8'h01, "rst_active");
    chk("rst_active comb after", y_comb, 8'h01);

    // D toggling between edges with S=1
    @(negedge clk);
    rst = 1'b0; S = 3'd1; D = 1'b1;
    #1 chk("tog comb1", y_comb, 8'h02);
    #1 D = 1'b0;
    #1 chk("tog comb0", y_comb, 8'h00);
    D = 1'b1;
    #1 chk("tog comb1b", y_comb, 8'h02);
    push_exp(1'b0, 8'h02);
    @(posedge clk);
    #1 check_reg("tog edge1");
    #1 D = 1'b0;
    #1 chk("tog comb0b", y_comb, 8'h00);
    push_exp(1'b0, 8'h00);
    @(posedge clk);
    #1 check_reg("tog edge0");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
